// File: rtl/layer_ctrl_pkg.sv
// Shared types and sizing helpers for the layer sequencing controller.
package layer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned n_taps(input int unsigned chin, input int unsigned kdim);
        return kdim * kdim * chin;
    endfunction

    function automatic int unsigned n_pix(input int unsigned wout);
        return wout * wout;
    endfunction

    function automatic int unsigned tap_width(input int unsigned taps);
        return $clog2(taps);
    endfunction

    // One spare bit so a full pixel count is representable without aliasing.
    function automatic int unsigned pix_width(input int unsigned pix);
        return $clog2(pix) + 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear, enable and a wrap flag.
module mod_counter #(
    parameter int unsigned MOD = 2,
    parameter int unsigned W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap_c
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // High on the enabled cycle that rolls the count back to zero.
    assign wrap_c = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/mac_layer_ctrl.sv
// Sequences one conv layer: walks weight ROM taps per output pixel and pulses MAC clear/sample.
module mac_layer_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter  int unsigned CHIN       = 112,
    parameter  int unsigned KERNEL_DIM = 3,
    parameter  int unsigned WOUT       = 8,
    localparam int unsigned N_TAPS     = n_taps(CHIN, KERNEL_DIM),
    localparam int unsigned N_PIX      = n_pix(WOUT),
    localparam int unsigned AW         = tap_width(N_TAPS),
    localparam int unsigned PW         = pix_width(N_PIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ifm_valid,
    input  logic          ram_feedback,
    output logic          layer_en,
    output logic [AW-1:0] rom_addr,
    output logic          clr_pulse,
    output logic          sample,
    output logic [PW-1:0] pix_idx,
    output logic          busy,
    output logic          finish
);

    state_t        state;
    logic          drain_2nd;
    logic          accept_c;
    logic          tap_wrap_c;
    logic          pix_wrap_c;
    logic          cnt_clr_c;
    logic [PW-1:0] pix_cnt;
    logic [PW-1:0] clr_idx;

    assign accept_c  = (state == RUN) && ifm_valid;
    assign cnt_clr_c = (state == IDLE);

    // The tap counter is the ROM address itself, so the two can never diverge.
    mod_counter #(.MOD(N_TAPS), .W(AW)) u_tap_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_c),
        .en     (accept_c),
        .count  (rom_addr),
        .wrap_c (tap_wrap_c)
    );

    // Advances once per completed pixel; its wrap marks the last pixel of the layer.
    mod_counter #(.MOD(N_PIX), .W(PW)) u_pix_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_c),
        .en     (tap_wrap_c),
        .count  (pix_cnt),
        .wrap_c (pix_wrap_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_2nd <= 1'b0;
            layer_en  <= 1'b0;
            clr_pulse <= 1'b0;
            sample    <= 1'b0;
            clr_idx   <= '0;
            pix_idx   <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            layer_en  <= accept_c;
            clr_pulse <= tap_wrap_c;
            sample    <= clr_pulse;
            // Pixel number rides alongside clr_pulse, then lands on pix_idx with sample.
            if (tap_wrap_c) begin
                clr_idx <= pix_cnt;
            end
            if (clr_pulse) begin
                pix_idx <= clr_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (pix_wrap_c) begin
                        state     <= DRAIN;
                        drain_2nd <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Two cycles: one for the last clr_pulse, one for the last sample.
                    if (drain_2nd) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                    end else begin
                        drain_2nd <= 1'b1;
                    end
                end
                DONE: begin
                    if (ram_feedback) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    finish <= 1'b0;
                end
            endcase
        end
    end

endmodule
